mem_sequencer: RTL and testbench

Memory access sequencer sitting directly upstream of the `ram` block. It accepts one load/store request at a time from the control unit over a valid/ready handshake and drives the RAM's address-register, write, section-select and output-enable strobes in the correct cycle order. For loads it captures the read byte and returns it over a valid/ready response channel. It skips the address-load cycle when the requested address is already latched in the RAM.

---
 rtl/mem_pkg.sv | 16 +
 rtl/mem_sequencer.sv | 140 ++++++++++++++
 tb/tb_mem_sequencer.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the RAM access sequencer.
package mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WRITE,
        READ,
        RESP
    } e_memSeqState;

    localparam logic C_SEL_PROGRAM = 1'b0;
    localparam logic C_SEL_DATA    = 1'b1;
    localparam int   C_WAIT_W      = 4;

endpackage

// File: rtl/mem_sequencer.sv
// Sequences one load/store at a time onto the RAM strobes, skipping the
// address-load cycle when the RAM already holds the requested address.
module mem_sequencer
    import mem_pkg::*;
#(
    parameter int P_READ_WAIT = 1
) (
    input  logic       i_clk,
    input  logic       i_nReset,
    input  logic       i_reqValid,
    output logic       o_reqReady,
    input  logic       i_reqWrite,
    input  logic       i_reqData,
    input  logic [7:0] i_reqAddr,
    input  logic [7:0] i_reqWdata,
    output logic       o_rspValid,
    output logic [7:0] o_rspData,
    input  logic       i_rspReady,
    output logic [7:0] o_ramAddress,
    output logic       o_ramAddressEn,
    output logic [7:0] o_ramWriteData,
    output logic       o_ramWriteEn,
    output logic       o_ramReadDataSelect,
    output logic       o_ramOutEnable,
    input  logic [7:0] i_ramReadData,
    output logic       o_busy
);

    localparam logic [C_WAIT_W-1:0] C_WAIT_LOAD = C_WAIT_W'(P_READ_WAIT - 1);

    e_memSeqState          r_state;
    e_memSeqState          w_stateNext;
    logic [7:0]            r_addr;
    logic [7:0]            r_wdata;
    logic                  r_write;
    logic                  r_sel;
    logic [7:0]            r_lastAddr;
    logic                  r_addrValid;
    logic [C_WAIT_W-1:0]   r_waitCnt;
    logic [7:0]            r_rspData;
    logic                  w_hit;
    logic                  w_accept;
    logic                  w_enterRead;

    assign w_hit       = r_addrValid && (i_reqAddr == r_lastAddr);
    assign w_accept    = (r_state == IDLE) && i_reqValid;
    assign w_enterRead = (w_stateNext == READ) && (r_state != READ);

    always_ff @(posedge i_clk or negedge i_nReset) begin
        if (!i_nReset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext         = r_state;
        o_reqReady          = 1'b0;
        o_busy              = 1'b1;
        o_ramAddressEn      = 1'b0;
        o_ramWriteEn        = 1'b0;
        o_ramOutEnable      = 1'b0;
        o_ramReadDataSelect = C_SEL_PROGRAM;
        o_rspValid          = 1'b0;
        case (r_state)
            IDLE: begin
                o_reqReady = 1'b1;
                o_busy     = 1'b0;
                if (i_reqValid) begin
                    if (!w_hit) begin
                        w_stateNext = ADDR;
                    end else begin
                        w_stateNext = i_reqWrite ? WRITE : READ;
                    end
                end
            end
            ADDR: begin
                o_ramAddressEn = 1'b1;
                w_stateNext    = r_write ? WRITE : READ;
            end
            WRITE: begin
                o_ramWriteEn = 1'b1;
                w_stateNext  = IDLE;
            end
            READ: begin
                o_ramOutEnable      = 1'b1;
                o_ramReadDataSelect = r_sel;
                if (r_waitCnt == '0) begin
                    w_stateNext = RESP;
                end
            end
            RESP: begin
                o_rspValid = 1'b1;
                if (i_rspReady) begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // Request capture, address cache, read wait counter and response data.
    always_ff @(posedge i_clk or negedge i_nReset) begin
        if (!i_nReset) begin
            r_addr      <= '0;
            r_wdata     <= '0;
            r_write     <= 1'b0;
            r_sel       <= C_SEL_PROGRAM;
            r_lastAddr  <= '0;
            r_addrValid <= 1'b0;
            r_waitCnt   <= '0;
            r_rspData   <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= i_reqAddr;
                r_wdata <= i_reqWdata;
                r_write <= i_reqWrite;
                r_sel   <= i_reqWrite ? C_SEL_DATA : i_reqData;
            end
            if (r_state == ADDR) begin
                r_lastAddr  <= r_addr;
                r_addrValid <= 1'b1;
            end
            if (w_enterRead) begin
                r_waitCnt <= C_WAIT_LOAD;
            end else if ((r_state == READ) && (r_waitCnt != '0)) begin
                r_waitCnt <= r_waitCnt - 1'b1;
            end
            if ((r_state == READ) && (r_waitCnt == '0)) begin
                r_rspData <= i_ramReadData;
            end
        end
    end

    assign o_ramAddress   = r_addr;
    assign o_ramWriteData = r_wdata;
    assign o_rspData      = r_rspData;

endmodule

// File: tb/tb_mem_sequencer.sv
// Two sequencers (read wait 1 and 3) in front of a bench RAM, checked every
// cycle against a transaction-timeline model plus directed literal checks.
module tb_mem_sequencer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] nrst, req_valid, req_write, req_data, rsp_ready;
    logic [7:0] req_addr [2];
    logic [7:0] req_wdata [2];
    logic [7:0] garbage [2];
    logic [1:0] req_ready, rsp_valid, ram_ae, ram_we, ram_sel, ram_oe, busy;
    logic [7:0] rsp_data [2];
    logic [7:0] ram_addr [2];
    logic [7:0] ram_wdata [2];
    logic [7:0] ram_rdata [2];

    // Bench RAM: data section is writable, program section is a fixed pattern.
    logic [7:0] dmem [2][256];
    logic [7:0] areg [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        mem_sequencer #(.P_READ_WAIT(gi == 0 ? 1 : 3)) u_dut (
            .i_clk               (clk),
            .i_nReset            (nrst[gi]),
            .i_reqValid          (req_valid[gi]),
            .o_reqReady          (req_ready[gi]),
            .i_reqWrite          (req_write[gi]),
            .i_reqData           (req_data[gi]),
            .i_reqAddr           (req_addr[gi]),
            .i_reqWdata          (req_wdata[gi]),
            .o_rspValid          (rsp_valid[gi]),
            .o_rspData           (rsp_data[gi]),
            .i_rspReady          (rsp_ready[gi]),
            .o_ramAddress        (ram_addr[gi]),
            .o_ramAddressEn      (ram_ae[gi]),
            .o_ramWriteData      (ram_wdata[gi]),
            .o_ramWriteEn        (ram_we[gi]),
            .o_ramReadDataSelect (ram_sel[gi]),
            .o_ramOutEnable      (ram_oe[gi]),
            .i_ramReadData       (ram_rdata[gi]),
            .o_busy              (busy[gi])
        );
        assign ram_rdata[gi] = ram_oe[gi] ? (ram_sel[gi] ? dmem[gi][areg[gi]] : (areg[gi] ^ 8'hE3))
                                          : garbage[gi];
    end

    int  n_checks = 0;
    int  n_errors = 0;
    int  tcyc = 0;
    bit  rand_rdy = 1'b0;

    // Model state: one outstanding transaction and its age in cycles.
    bit         m_act [2];
    bit         m_wr [2];
    bit         m_sel [2];
    bit         m_miss [2];
    bit         m_cv [2];
    int         m_age [2];
    logic [7:0] m_addr [2];
    logic [7:0] m_wd [2];
    logic [7:0] m_rsp [2];
    logic [7:0] m_ca [2];

    int         n_ae [2];
    int         n_we [2];
    int         n_oe [2];
    int         n_oes [2];
    int         n_nr [2];
    int         n_rv [2];
    logic [7:0] last_ae [2];
    logic [7:0] last_we [2];

    function automatic int p_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic check(input string name, input int k, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s dut%0d at %0t: got 0x%0h, expected 0x%0h", name, k, $time, act, exp);
        end
    endtask

    task automatic cycle_check();
        for (int k = 0; k < 2; k++) begin
            int p;
            int alen;
            bit e_idle, e_ae, e_we, e_oe, e_rv;
            p = p_of(k);
            if (!nrst[k]) begin
                m_act[k] = 1'b0;
                m_cv[k] = 1'b0;
                m_addr[k] = 8'h00;
                m_wd[k] = 8'h00;
                m_rsp[k] = 8'h00;
            end
            alen   = m_miss[k] ? 1 : 0;
            e_idle = !m_act[k];
            e_ae   = m_act[k] && (m_age[k] < alen);
            e_we   = m_act[k] && m_wr[k] && (m_age[k] == alen);
            e_oe   = m_act[k] && !m_wr[k] && (m_age[k] >= alen) && (m_age[k] < alen + p);
            e_rv   = m_act[k] && !m_wr[k] && (m_age[k] >= alen + p);

            check("reqReady", k, int'(req_ready[k]), int'(e_idle));
            check("busy", k, int'(busy[k]), int'(!e_idle));
            check("ramAddressEn", k, int'(ram_ae[k]), int'(e_ae));
            check("ramAddress", k, int'(ram_addr[k]), int'(m_addr[k]));
            check("ramWriteEn", k, int'(ram_we[k]), int'(e_we));
            check("ramWriteData", k, int'(ram_wdata[k]), int'(m_wd[k]));
            check("ramOutEnable", k, int'(ram_oe[k]), int'(e_oe));
            check("ramReadDataSelect", k, int'(ram_sel[k]), int'(e_oe && m_sel[k]));
            check("rspValid", k, int'(rsp_valid[k]), int'(e_rv));
            check("rspData", k, int'(rsp_data[k]), int'(m_rsp[k]));

            n_ae[k]  += int'(ram_ae[k]);
            n_we[k]  += int'(ram_we[k]);
            n_oe[k]  += int'(ram_oe[k]);
            n_oes[k] += int'(ram_oe[k] && ram_sel[k]);
            n_nr[k]  += int'(!req_ready[k]);
            n_rv[k]  += int'(rsp_valid[k]);
            if (ram_ae[k]) last_ae[k] = ram_addr[k];
            if (ram_we[k]) last_we[k] = ram_wdata[k];

            if (nrst[k]) begin
                if (e_idle) begin
                    if (req_valid[k]) begin
                        m_act[k]  = 1'b1;
                        m_age[k]  = 0;
                        m_wr[k]   = req_write[k];
                        m_sel[k]  = req_write[k] ? 1'b1 : req_data[k];
                        m_addr[k] = req_addr[k];
                        m_wd[k]   = req_wdata[k];
                        m_miss[k] = !(m_cv[k] && (m_ca[k] == req_addr[k]));
                    end
                end else begin
                    if (e_ae) begin
                        m_cv[k] = 1'b1;
                        m_ca[k] = m_addr[k];
                    end
                    if (e_oe && (m_age[k] == alen + p - 1)) m_rsp[k] = ram_rdata[k];
                    if (e_we || (e_rv && rsp_ready[k])) m_act[k] = 1'b0;
                    else m_age[k]++;
                end
                if (ram_we[k]) dmem[k][areg[k]] = ram_wdata[k];
                if (ram_ae[k]) areg[k] = ram_addr[k];
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cycle_check();
        @(posedge clk);
        #1;
        tcyc++;
        for (int k = 0; k < 2; k++) garbage[k] = 8'($urandom);
        if (rand_rdy) rsp_ready = 2'($urandom_range(0, 3));
    endtask

    task automatic issue(input int k, input bit w, input bit d, input logic [7:0] a,
                         input logic [7:0] wd, output int acc);
        int n;
        req_valid[k] = 1'b1;
        req_write[k] = w;
        req_data[k]  = d;
        req_addr[k]  = a;
        req_wdata[k] = wd;
        n = 0;
        while (!req_ready[k] && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("accept_timeout", k, 0, 1);
        acc = tcyc;
        tick();
        req_valid[k] = 1'b0;
        $display("dut%0d cycle %0d: %s addr=0x%02h wdata=0x%02h section=%0d", k, acc,
                 w ? "store" : "load ", a, wd, d);
    endtask

    task automatic get_rsp(input int k, output int lat, output logic [7:0] d);
        lat = 1;
        while (!rsp_valid[k] && lat < 100) begin
            tick();
            lat++;
        end
        if (lat >= 100) check("rsp_timeout", k, 0, 1);
        d = rsp_data[k];
        tick();
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        while (busy[k] && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("idle_timeout", k, 0, 1);
    endtask

    initial begin
        int acc, acc2, lat, n;
        int s_ae, s_we, s_oe, s_oes, s_nr, s_rv;
        logic [7:0] d;

        nrst = 2'b00;
        req_valid = 2'b00;
        req_write = 2'b00;
        req_data = 2'b00;
        rsp_ready = 2'b11;
        for (int k = 0; k < 2; k++) begin
            req_addr[k] = 8'h00;
            req_wdata[k] = 8'h00;
            garbage[k] = 8'h00;
            areg[k] = 8'h00;
            n_ae[k] = 0; n_we[k] = 0; n_oe[k] = 0; n_oes[k] = 0; n_nr[k] = 0; n_rv[k] = 0;
            m_act[k] = 1'b0; m_cv[k] = 1'b0; m_miss[k] = 1'b0; m_age[k] = 0;
            for (int a = 0; a < 256; a++) dmem[k][a] = 8'h00;
        end
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            check("rst_reqReady", k, int'(req_ready[k]), 1);
            check("rst_rspData", k, int'(rsp_data[k]), 0);
            check("rst_busy", k, int'(busy[k]), 0);
        end
        nrst = 2'b11;
        tick();

        // Store miss: one address pulse, one write pulse, two not-ready cycles.
        s_ae = n_ae[0]; s_we = n_we[0]; s_nr = n_nr[0];
        issue(0, 1'b1, 1'b0, 8'h10, 8'h5A, acc);
        wait_idle(0);
        check("st_addrEn_pulses", 0, n_ae[0] - s_ae, 1);
        check("st_addr", 0, int'(last_ae[0]), 8'h10);
        check("st_wrEn_pulses", 0, n_we[0] - s_we, 1);
        check("st_wdata", 0, int'(last_we[0]), 8'h5A);
        check("st_notReady_cycles", 0, n_nr[0] - s_nr, 2);

        // Load hit from the data section.
        s_ae = n_ae[0]; s_oe = n_oe[0]; s_oes = n_oes[0];
        issue(0, 1'b0, 1'b1, 8'h10, 8'h00, acc);
        get_rsp(0, lat, d);
        check("ldhit_addrEn_pulses", 0, n_ae[0] - s_ae, 0);
        check("ldhit_oe_cycles", 0, n_oe[0] - s_oe, 1);
        check("ldhit_sel_data", 0, n_oes[0] - s_oes, 1);
        check("ldhit_latency", 0, lat, 2);
        check("ldhit_data", 0, int'(d), 8'h5A);

        // Back-to-back: load presented while the store is in flight.
        issue(0, 1'b1, 1'b0, 8'h11, 8'h77, acc);
        issue(0, 1'b0, 1'b1, 8'h11, 8'h00, acc2);
        get_rsp(0, lat, d);
        check("b2b_accept_gap", 0, acc2 - acc, 3);
        check("b2b_latency", 0, lat, 2);
        check("b2b_data", 0, int'(d), 8'h77);

        // Program-section load miss with a 3-cycle read wait.
        s_ae = n_ae[1]; s_oe = n_oe[1]; s_oes = n_oes[1];
        issue(1, 1'b0, 1'b0, 8'h20, 8'h00, acc);
        get_rsp(1, lat, d);
        check("ldp_addrEn_pulses", 1, n_ae[1] - s_ae, 1);
        check("ldp_oe_cycles", 1, n_oe[1] - s_oe, 3);
        check("ldp_sel_data", 1, n_oes[1] - s_oes, 0);
        check("ldp_latency", 1, lat, 5);
        check("ldp_data", 1, int'(d), 8'hC3);

        // Response stall with a new request waiting.
        rsp_ready[1] = 1'b0;
        issue(1, 1'b0, 1'b0, 8'h20, 8'h00, acc);
        req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 8'h21; req_wdata[1] = 8'h33;
        n = 0;
        while (!rsp_valid[1] && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("stall_rsp_timeout", 1, 0, 1);
        s_ae = n_ae[1]; s_we = n_we[1]; s_oe = n_oe[1]; s_nr = n_nr[1]; s_rv = n_rv[1];
        repeat (5) tick();
        check("stall_strobes", 1, (n_ae[1] - s_ae) + (n_we[1] - s_we) + (n_oe[1] - s_oe), 0);
        check("stall_notReady", 1, n_nr[1] - s_nr, 5);
        check("stall_rspValid", 1, n_rv[1] - s_rv, 5);
        check("stall_rspData", 1, int'(rsp_data[1]), 8'hC3);
        rsp_ready[1] = 1'b1;
        issue(1, 1'b1, 1'b0, 8'h21, 8'h33, acc);
        wait_idle(1);

        // Reset during READ drops the response and invalidates the cache.
        issue(1, 1'b0, 1'b1, 8'h30, 8'h00, acc);
        n = 0;
        while (!ram_oe[1] && n < 20) begin
            tick();
            n++;
        end
        nrst[1] = 1'b0;
        #1;
        check("rstrd_oe", 1, int'(ram_oe[1]), 0);
        check("rstrd_reqReady", 1, int'(req_ready[1]), 1);
        check("rstrd_rspValid", 1, int'(rsp_valid[1]), 0);
        check("rstrd_ramAddress", 1, int'(ram_addr[1]), 0);
        tick();
        nrst[1] = 1'b1;
        s_ae = n_ae[1];
        issue(1, 1'b0, 1'b1, 8'h30, 8'h00, acc);
        get_rsp(1, lat, d);
        check("rstrd_reload_addrEn", 1, n_ae[1] - s_ae, 1);

        // Store cut off by reset before its write edge leaves memory untouched.
        s_we = n_we[1];
        issue(1, 1'b1, 1'b0, 8'h40, 8'h99, acc);
        nrst[1] = 1'b0;
        tick();
        nrst[1] = 1'b1;
        issue(1, 1'b0, 1'b1, 8'h40, 8'h00, acc);
        get_rsp(1, lat, d);
        check("rstst_wrEn_pulses", 1, n_we[1] - s_we, 0);
        check("rstst_data", 1, int'(d), 8'h00);

        // 0xFF then 0x00 are distinct addresses.
        s_ae = n_ae[0];
        issue(0, 1'b1, 1'b0, 8'hFF, 8'hA5, acc);
        wait_idle(0);
        check("wrap_addr_ff", 0, int'(last_ae[0]), 8'hFF);
        issue(0, 1'b0, 1'b1, 8'h00, 8'h00, acc);
        get_rsp(0, lat, d);
        check("wrap_addrEn_pulses", 0, n_ae[0] - s_ae, 2);
        check("wrap_addr_00", 0, int'(last_ae[0]), 8'h00);
        check("wrap_data", 0, int'(d), 8'h00);

        // Randomised traffic with a random consumer and occasional resets.
        rand_rdy = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 200; i++) begin
                logic [7:0] a;
                case ($urandom_range(0, 3))
                    0: a = 8'h00;
                    1: a = 8'hFF;
                    2: a = 8'h10;
                    default: a = 8'($urandom);
                endcase
                repeat ($urandom_range(0, 2)) tick();
                issue(k, 1'($urandom), 1'($urandom), a, 8'($urandom), acc);
                if ($urandom_range(0, 39) == 0) begin
                    repeat ($urandom_range(0, 3)) tick();
                    nrst[k] = 1'b0;
                    tick();
                    nrst[k] = 1'b1;
                end
            end
        end
        rand_rdy = 1'b0;
        rsp_ready = 2'b11;
        repeat (20) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
